ysyx_22050019_axi_arbiter: RTL and testbench

YSYX_22050019_AXI_ARBITER -- requirements
Module: ysyx_22050019_axi_arbiter

---
 rtl/ysyx_22050019_axi_arbiter.sv | 123 ++++++++++++
 tb/tb_ysyx_22050019_axi_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050019_axi_arbiter.sv
// ysyx_22050019_axi_arbiter: shares one AXI memory port between IFU reads and LSU reads/writes.
// Reads are round-robin arbitrated. An LSU read waits for any in-progress LSU write so it
// cannot overtake it, and a new write waits while an LSU read owns the read channel.
module ysyx_22050019_axi_arbiter #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ifu_ar_valid,
    output logic                        ifu_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   ifu_ar_addr,
    output logic                        ifu_r_valid,
    input  logic                        ifu_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   ifu_r_data,
    output logic [1:0]                  ifu_r_resp,
    input  logic                        lsu_ar_valid,
    output logic                        lsu_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   lsu_ar_addr,
    output logic                        lsu_r_valid,
    input  logic                        lsu_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   lsu_r_data,
    output logic [1:0]                  lsu_r_resp,
    input  logic                        lsu_aw_valid,
    output logic                        lsu_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   lsu_aw_addr,
    input  logic                        lsu_w_valid,
    output logic                        lsu_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   lsu_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] lsu_w_strb,
    output logic                        lsu_b_valid,
    input  logic                        lsu_b_ready,
    output logic [1:0]                  lsu_b_resp,
    output logic                        mem_ar_valid,
    input  logic                        mem_ar_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   mem_ar_addr,
    input  logic                        mem_r_valid,
    output logic                        mem_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_r_data,
    input  logic [1:0]                  mem_r_resp,
    output logic                        mem_aw_valid,
    input  logic                        mem_aw_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   mem_aw_addr,
    output logic                        mem_w_valid,
    input  logic                        mem_w_ready,
    output logic [AXI_DATA_WIDTH-1:0]   mem_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] mem_w_strb,
    input  logic                        mem_b_valid,
    output logic                        mem_b_ready,
    input  logic [1:0]                  mem_b_resp
);
    typedef enum logic [1:0] {R_IDLE, R_IFU, R_LSU} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;
    logic     last_lsu;
    logic     ifu_elig, lsu_elig, pick_lsu;
    logic     r_idle, to_ifu, to_lsu, aw_own, w_own, b_own;
    logic     ar_fire, r_fire, aw_fire, w_fire, b_fire;

    assign ifu_elig = ifu_ar_valid;
    assign lsu_elig = lsu_ar_valid && w_state == W_IDLE && !lsu_aw_valid;
    assign pick_lsu = lsu_elig && (!ifu_elig || !last_lsu);
    assign r_idle   = !rst && r_state == R_IDLE;
    assign to_ifu   = !rst && r_state == R_IFU;
    assign to_lsu   = !rst && r_state == R_LSU;
    assign aw_own   = !rst && w_state == W_IDLE && r_state != R_LSU;
    assign w_own    = !rst && w_state == W_DATA;
    assign b_own    = !rst && w_state == W_RESP;
    assign ar_fire  = mem_ar_valid && mem_ar_ready;
    assign r_fire   = mem_r_valid && mem_r_ready;
    assign aw_fire  = mem_aw_valid && mem_aw_ready;
    assign w_fire   = mem_w_valid && mem_w_ready;
    assign b_fire   = mem_b_valid && mem_b_ready;

    // state registers and round-robin history (last_lsu=0 means IFU was granted last)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            w_state  <= W_IDLE;
            last_lsu <= 1'b0;
        end else begin
            r_state  <= r_next;
            w_state  <= w_next;
            if (ar_fire) last_lsu <= pick_lsu;
        end
    end

    // next-state logic for both channel FSMs, advanced only by handshakes
    always_comb begin
        r_next = r_state == R_IDLE ? (ar_fire ? (pick_lsu ? R_LSU : R_IFU) : R_IDLE)
                                   : (r_fire ? R_IDLE : r_state);
        w_next = w_state == W_IDLE ? (aw_fire ? W_DATA : W_IDLE)
               : w_state == W_DATA ? (w_fire ? W_RESP : W_DATA)
                                   : (b_fire ? W_IDLE : W_RESP);
    end

    // channel routing: each channel only passes through in its owning state, zeros elsewhere
    always_comb begin
        mem_ar_valid = r_idle && (ifu_elig || lsu_elig);
        mem_ar_addr  = mem_ar_valid ? (pick_lsu ? lsu_ar_addr : ifu_ar_addr) : '0;
        ifu_ar_ready = r_idle && ifu_elig && !pick_lsu && mem_ar_ready;
        lsu_ar_ready = r_idle && pick_lsu && mem_ar_ready;
        ifu_r_valid  = to_ifu && mem_r_valid;
        ifu_r_data   = ifu_r_valid ? mem_r_data : '0;
        ifu_r_resp   = ifu_r_valid ? mem_r_resp : '0;
        lsu_r_valid  = to_lsu && mem_r_valid;
        lsu_r_data   = lsu_r_valid ? mem_r_data : '0;
        lsu_r_resp   = lsu_r_valid ? mem_r_resp : '0;
        mem_r_ready  = (to_ifu && ifu_r_ready) || (to_lsu && lsu_r_ready);
        mem_aw_valid = aw_own && lsu_aw_valid;
        mem_aw_addr  = mem_aw_valid ? lsu_aw_addr : '0;
        lsu_aw_ready = aw_own && mem_aw_ready;
        mem_w_valid  = w_own && lsu_w_valid;
        mem_w_data   = mem_w_valid ? lsu_w_data : '0;
        mem_w_strb   = mem_w_valid ? lsu_w_strb : '0;
        lsu_w_ready  = w_own && mem_w_ready;
        lsu_b_valid  = b_own && mem_b_valid;
        lsu_b_resp   = lsu_b_valid ? mem_b_resp : '0;
        mem_b_ready  = b_own && lsu_b_ready;
    end
endmodule

// File: tb/tb_ysyx_22050019_axi_arbiter.sv
// tb_ysyx_22050019_axi_arbiter: scoreboard bench with a behavioural memory and two masters.
module tb_ysyx_22050019_axi_arbiter;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic        ifu_ar_valid = 0, ifu_ar_ready, ifu_r_valid, ifu_r_ready = 0;
    logic [63:0] ifu_ar_addr = 0, ifu_r_data;
    logic [1:0]  ifu_r_resp;
    logic        lsu_ar_valid = 0, lsu_ar_ready, lsu_r_valid, lsu_r_ready = 0;
    logic [63:0] lsu_ar_addr = 0, lsu_r_data;
    logic [1:0]  lsu_r_resp;
    logic        lsu_aw_valid = 0, lsu_aw_ready, lsu_w_valid = 0, lsu_w_ready, lsu_b_valid, lsu_b_ready = 0;
    logic [63:0] lsu_aw_addr = 0, lsu_w_data = 0;
    logic [7:0]  lsu_w_strb = 0;
    logic [1:0]  lsu_b_resp;
    logic        mem_ar_valid, mem_ar_ready, mem_r_valid, mem_r_ready;
    logic [63:0] mem_ar_addr, mem_r_data;
    logic [1:0]  mem_r_resp;
    logic        mem_aw_valid, mem_aw_ready, mem_w_valid, mem_w_ready, mem_b_valid, mem_b_ready;
    logic [63:0] mem_aw_addr, mem_w_data;
    logic [7:0]  mem_w_strb;
    logic [1:0]  mem_b_resp;

    ysyx_22050019_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready), .ifu_ar_addr(ifu_ar_addr),
        .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready), .ifu_r_data(ifu_r_data), .ifu_r_resp(ifu_r_resp),
        .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready), .lsu_ar_addr(lsu_ar_addr),
        .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready), .lsu_r_data(lsu_r_data), .lsu_r_resp(lsu_r_resp),
        .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(lsu_aw_ready), .lsu_aw_addr(lsu_aw_addr),
        .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready), .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb),
        .lsu_b_valid(lsu_b_valid), .lsu_b_ready(lsu_b_ready), .lsu_b_resp(lsu_b_resp),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp),
        .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready), .mem_aw_addr(mem_aw_addr),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready), .mem_w_data(mem_w_data), .mem_w_strb(mem_w_strb),
        .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready), .mem_b_resp(mem_b_resp)
    );

    int checks = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected read responses per master, expected memory writes and B responses
    logic [65:0]  ifu_q[$], lsu_q[$];
    logic [135:0] w_q[$];
    logic [1:0]   b_q[$];
    int           grants[$];
    logic [65:0]  exp_r;
    logic [1:0]   exp_b;
    logic [135:0] exp_w;

    // knobs for the memory model: ar_mode 0=random ready, 1=always ready, 2=never ready
    int ar_mode = 1, r_lat = -1, b_lat = -1;
    bit stray = 0, rr_rand = 0;

    task automatic check(input bit ok, input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // memory contents: a fixed pattern plus one known word
    function automatic logic [63:0] rdata(input logic [63:0] a);
        return a == 64'h8000_0000 ? 64'h1122_3344_5566_7788 : {a[31:0] ^ 32'hdead_beef, ~a[31:0]};
    endfunction

    // behavioural memory: one read at a time, one write at a time, fixed or random latency
    bit          m_ar, m_r, m_aw, m_w, m_b, m_rst, rd_busy = 0, b_pend = 0;
    int          rd_cnt = 0, b_cnt = 0;
    logic [63:0] m_ar_addr, m_aw_addr, m_w_data, rd_addr = 0, wa = 0;
    logic [7:0]  m_w_strb;
    initial begin
        mem_ar_ready = 0; mem_r_valid = 0; mem_r_data = 0; mem_r_resp = 0;
        mem_aw_ready = 0; mem_w_ready = 0; mem_b_valid = 0; mem_b_resp = 0;
        forever begin
            @(negedge clk);
            m_ar = mem_ar_valid && mem_ar_ready; m_r = mem_r_valid && mem_r_ready;
            m_aw = mem_aw_valid && mem_aw_ready; m_w = mem_w_valid && mem_w_ready;
            m_b = mem_b_valid && mem_b_ready; m_rst = rst;
            m_ar_addr = mem_ar_addr; m_aw_addr = mem_aw_addr; m_w_data = mem_w_data; m_w_strb = mem_w_strb;
            @(posedge clk); #1;
            if (m_rst) begin
                rd_busy = 0; b_pend = 0; mem_r_valid = 0; mem_b_valid = 0;
            end else begin
                if (m_r) begin rd_busy = 0; mem_r_valid = 0; end
                if (m_ar) begin
                    rd_busy = 1; rd_addr = m_ar_addr;
                    rd_cnt = r_lat < 0 ? int'($urandom_range(0, 4)) : r_lat;
                end
                if (m_aw) wa = m_aw_addr;
                if (m_w) begin
                    exp_w = w_q.size() != 0 ? w_q.pop_front() : '0;
                    check({wa, m_w_data, m_w_strb} == exp_w, "mem write addr/data/strb", {wa, m_w_data, m_w_strb}, exp_w);
                    b_pend = 1; b_cnt = b_lat < 0 ? int'($urandom_range(0, 3)) : b_lat;
                end
                if (m_b) begin b_pend = 0; mem_b_valid = 0; end
                if (rd_busy && !mem_r_valid) begin
                    if (rd_cnt == 0) begin
                        mem_r_valid = 1; mem_r_data = rdata(rd_addr); mem_r_resp = rd_addr[5:4];
                    end else rd_cnt--;
                end
                if (!rd_busy) begin
                    mem_r_valid = stray; mem_r_data = stray ? 64'hbad0_bad0_bad0_bad0 : 64'h0; mem_r_resp = 2'b10;
                end
                if (b_pend && !mem_b_valid) begin
                    if (b_cnt == 0) begin mem_b_valid = 1; mem_b_resp = wa[5:4]; end
                    else b_cnt--;
                end
            end
            mem_ar_ready = ar_mode == 1 || (ar_mode == 0 && $urandom_range(0, 1) == 1);
            mem_aw_ready = $urandom_range(0, 3) != 0;
            mem_w_ready  = $urandom_range(0, 3) != 0;
        end
    end

    // response-side readiness of the masters
    always @(posedge clk) begin
        #1;
        ifu_r_ready = !rr_rand || $urandom_range(0, 1) == 1;
        lsu_r_ready = !rr_rand || $urandom_range(0, 1) == 1;
        lsu_b_ready = !rr_rand || $urandom_range(0, 1) == 1;
    end

    // monitor: tracks which master owns the read channel and pops the scoreboard on responses
    int owner = 0, ar_fires = 0, ifu_ar_cyc = 0, lsu_ar_cyc = 0, b_cyc = 0;
    bit wr_busy = 0;
    always @(negedge clk) begin
        if (rst) begin
            check({mem_ar_valid, mem_r_ready, mem_aw_valid, mem_w_valid, mem_b_ready, ifu_ar_ready, ifu_r_valid,
                   lsu_ar_ready, lsu_r_valid, lsu_aw_ready, lsu_w_ready, lsu_b_valid} == 0,
                  "valid/ready quiet during reset", {mem_ar_valid, mem_r_ready, ifu_r_valid, lsu_r_valid}, 0);
            owner = 0; wr_busy = 0;
        end else begin
            if (lsu_aw_valid) wr_busy = 1;
            check(owner == 1 || !ifu_r_valid, "ifu_r_valid without grant", ifu_r_valid, 0);
            check(owner == 2 || !lsu_r_valid, "lsu_r_valid without grant", lsu_r_valid, 0);
            if (owner == 0) check(!mem_r_ready, "mem_r_ready with no read outstanding", mem_r_ready, 0);
            if (!ifu_r_valid) check(ifu_r_data == 0, "ifu_r_data zero when invalid", ifu_r_data, 0);
            if (!lsu_r_valid) check(lsu_r_data == 0, "lsu_r_data zero when invalid", lsu_r_data, 0);
            if (!mem_ar_valid) check(mem_ar_addr == 0, "mem_ar_addr zero when invalid", mem_ar_addr, 0);
            if (wr_busy && lsu_ar_valid && mem_ar_valid)
                check(mem_ar_addr != lsu_ar_addr, "lsu read overtook pending write", mem_ar_addr, 0);
            if (ifu_r_valid && ifu_r_ready) begin
                check(ifu_q.size() != 0, "ifu response expected", ifu_q.size(), 1);
                if (ifu_q.size() != 0) begin
                    exp_r = ifu_q.pop_front();
                    check({ifu_r_resp, ifu_r_data} == exp_r, "ifu_r resp/data", {ifu_r_resp, ifu_r_data}, exp_r);
                end
                owner = 0;
            end
            if (lsu_r_valid && lsu_r_ready) begin
                check(lsu_q.size() != 0, "lsu response expected", lsu_q.size(), 1);
                if (lsu_q.size() != 0) begin
                    exp_r = lsu_q.pop_front();
                    check({lsu_r_resp, lsu_r_data} == exp_r, "lsu_r resp/data", {lsu_r_resp, lsu_r_data}, exp_r);
                end
                owner = 0;
            end
            if (lsu_b_valid && lsu_b_ready) begin
                exp_b = b_q.size() != 0 ? b_q.pop_front() : 2'bxx;
                check(lsu_b_resp == exp_b, "lsu_b_resp", lsu_b_resp, exp_b);
                b_cyc = cyc; wr_busy = 0;
            end
            if (ifu_ar_valid && ifu_ar_ready) begin owner = 1; grants.push_back(1); ifu_ar_cyc = cyc; end
            if (lsu_ar_valid && lsu_ar_ready) begin owner = 2; grants.push_back(2); lsu_ar_cyc = cyc; end
            if (mem_ar_valid && mem_ar_ready) ar_fires++;
        end
    end

    task automatic ifu_read(input logic [63:0] a);
        @(posedge clk); #1;
        ifu_ar_valid = 1; ifu_ar_addr = a;
        ifu_q.push_back({a[5:4], rdata(a)});
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifu_ar_ready) break;
        end
        check(ifu_ar_ready, "ifu_ar handshake", ifu_ar_ready, 1);
        @(posedge clk); #1;
        ifu_ar_valid = 0; ifu_ar_addr = 0;
    endtask

    task automatic lsu_read(input logic [63:0] a);
        @(posedge clk); #1;
        lsu_ar_valid = 1; lsu_ar_addr = a;
        lsu_q.push_back({a[5:4], rdata(a)});
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (lsu_ar_ready) break;
        end
        check(lsu_ar_ready, "lsu_ar handshake", lsu_ar_ready, 1);
        @(posedge clk); #1;
        lsu_ar_valid = 0; lsu_ar_addr = 0;
    endtask

    task automatic lsu_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        @(posedge clk); #1;
        lsu_aw_valid = 1; lsu_aw_addr = a;
        w_q.push_back({a, d, s});
        b_q.push_back(a[5:4]);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (lsu_aw_ready) break;
        end
        check(lsu_aw_ready, "lsu_aw handshake", lsu_aw_ready, 1);
        @(posedge clk); #1;
        lsu_aw_valid = 0; lsu_aw_addr = 0; lsu_w_valid = 1; lsu_w_data = d; lsu_w_strb = s;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (lsu_w_ready) break;
        end
        check(lsu_w_ready, "lsu_w handshake", lsu_w_ready, 1);
        @(posedge clk); #1;
        lsu_w_valid = 0; lsu_w_data = 0; lsu_w_strb = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && (ifu_q.size() != 0 || lsu_q.size() != 0 || b_q.size() != 0 || w_q.size() != 0); i++)
            @(negedge clk);
        check(ifu_q.size() + lsu_q.size() + b_q.size() + w_q.size() == 0, "all responses returned",
              ifu_q.size() + lsu_q.size() + b_q.size() + w_q.size(), 0);
    endtask

    int n0;
    initial begin
        repeat (3) @(posedge clk);
        #1; rst = 0;
        // tie straight out of reset: LSU first, then alternate
        r_lat = 1;
        fork
            begin lsu_read(64'h9000_0000); lsu_read(64'h9000_0018); end
            begin ifu_read(64'h8000_0008); ifu_read(64'h8000_0010); end
        join
        drain();
        check(grants.size() == 4, "tie grant count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            check(grants[i] == ((i % 2 == 1) ? 1 : 2), "tie grant order", grants[i], (i % 2 == 1) ? 1 : 2);
        // IFU alone, three-cycle memory latency, known data word
        r_lat = 3;
        ifu_read(64'h8000_0000);
        drain();
        // stray read response while idle
        stray = 1;
        repeat (4) @(negedge clk);
        check({mem_r_ready, ifu_r_valid, lsu_r_valid} == 0, "stray response ignored",
              {mem_r_valid, mem_r_ready, ifu_r_valid, lsu_r_valid}, 4'b1000);
        @(posedge clk); #1; stray = 0;
        repeat (2) @(posedge clk);
        // AR backpressure for five cycles
        ar_mode = 2; r_lat = 2;
        repeat (2) @(posedge clk);
        n0 = ar_fires;
        fork
            ifu_read(64'h8000_0030);
            begin
                @(posedge clk);
                repeat (5) begin
                    @(negedge clk);
                    check(mem_ar_valid && mem_ar_addr == 64'h8000_0030 && !ifu_ar_ready, "ar held under backpressure",
                          {mem_ar_valid, ifu_ar_ready, mem_ar_addr}, {2'b10, 64'h8000_0030});
                end
                ar_mode = 1;
            end
        join
        drain();
        check(ar_fires - n0 == 1, "single mem AR under backpressure", ar_fires - n0, 1);
        // read-after-write: LSU read waits for the B handshake, IFU proceeds
        b_lat = 6;
        fork
            lsu_write(64'h8000_0100, 64'h0123_4567_89ab_cdef, 8'hff);
            lsu_read(64'h8000_0100);
            ifu_read(64'h8000_0040);
        join
        drain();
        check(lsu_ar_cyc > b_cyc, "lsu read granted after write response", lsu_ar_cyc, b_cyc + 1);
        check(ifu_ar_cyc < b_cyc, "ifu read granted during write", ifu_ar_cyc, b_cyc);
        b_lat = -1;
        // reset while an LSU read is outstanding
        r_lat = 20;
        lsu_read(64'h9000_0008);
        check(owner == 2, "lsu owns read channel before reset", owner, 2);
        rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check({mem_ar_valid, mem_r_ready, ifu_r_valid, lsu_r_valid, mem_aw_valid, lsu_b_valid} == 0,
              "idle after reset", {mem_ar_valid, mem_r_ready, ifu_r_valid, lsu_r_valid}, 0);
        lsu_q.delete();
        r_lat = 2; grants.delete();
        fork
            ifu_read(64'h8000_0200);
            lsu_read(64'h9000_0010);
        join
        drain();
        check(grants.size() == 2 && grants[0] == 2 && grants[1] == 1, "tie order after reset",
              {grants.size(), grants.size() > 0 ? grants[0] : 0}, {32'd2, 32'd2});
        // randomized traffic on all channels
        rr_rand = 1; ar_mode = 0; r_lat = -1;
        fork
            for (int i = 0; i < 40; i++) ifu_read(64'h8000_0000 + 64'($urandom_range(1, 511)) * 8);
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 2) == 0)
                    lsu_write(64'h9000_0000 + 64'($urandom_range(0, 511)) * 8, {$urandom, $urandom}, 8'($urandom_range(1, 255)));
                else
                    lsu_read(64'h9000_0000 + 64'($urandom_range(0, 511)) * 8);
            end
        join
        drain();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
